// File: rtl/mem_bus_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mem_bus_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Which master currently owns (or last owned) the memory port.
  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam int DATA_W_DEF  = 64;
  localparam int TIMEOUT_DEF = 16;

  // Wait counter must be able to hold 0..TIMEOUT.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Owner selection between the two masters; round-robin when ARB_ROUND_ROBIN_EN is defined, else m0 priority.
// Latency: purely combinational.
// Backpressure: none; the caller only consults it while idle.
module arb_pick
  import mem_bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       valid,
  output owner_t     owner
);

  // Pick a winner among the pending requests.
  always_comb begin
    valid = |req;
    owner = OWN_M0;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, whoever did not win last time goes first.
    if (req == 2'b11) begin
      owner = (last_owner == OWN_M0) ? OWN_M1 : OWN_M0;
    end else if (req[1]) begin
      owner = OWN_M1;
    end
`else
    // The CPU always wins a tie; m1 only gets the port when m0 is quiet.
    if (!req[0] && req[1]) begin
      owner = OWN_M1;
    end
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // History is irrelevant under fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one data-memory port between the CPU (m0) and a loader/DMA port (m1); ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: request sampled in IDLE at N -> s_req from N+1 -> done one cycle after s_ready (min 2, max TIMEOUT+1).
// Backpressure: masters hold req until done; slave stalls via s_ready, bounded by TIMEOUT with an error completion.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: CPU load/store path
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  // master 1: loader / debug / DMA
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  // memory slave
  output logic              s_req,
  output logic              s_we,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  // CPU clock-gate stall
  output logic              cpu_stall
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  owner_t              owner_q;
  logic                we_q;
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                pick_vld;
  owner_t              pick_owner;
  owner_t              last_owner;
  logic                timeout_hit;
  logic                st_busy;
  logic                st_resp;

  assign st_busy     = (state_q == ST_BUSY);
  assign st_resp     = (state_q == ST_RESP);
  assign timeout_hit = (cnt_q == CNT_LAST);

  arb_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .valid      (pick_vld),
    .owner      (pick_owner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner_q;

  // Remember the most recent winner so the next tie goes the other way.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWN_M1;
    end else if ((state_q == ST_IDLE) && pick_vld) begin
      last_owner_q <= pick_owner;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_M1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, wait in BUSY (s_ready beats timeout), one RESP cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_vld)                state_d = ST_BUSY;
      ST_BUSY: if (s_ready || timeout_hit)  state_d = ST_RESP;
      ST_RESP:                              state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Transfer registers: latch the winner's request, then capture the response or the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            owner_q <= pick_owner;
            we_q    <= (pick_owner == OWN_M1) ? m1_we    : m0_we;
            addr_q  <= (pick_owner == OWN_M1) ? m1_addr  : m0_addr;
            wdata_q <= (pick_owner == OWN_M1) ? m1_wdata : m0_wdata;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            rdata_q <= s_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slave side: request only while BUSY; address/data come straight from the latches.
  assign s_req   = st_busy;
  assign s_we    = st_busy & we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

  // Master side: everything is forced to zero for whoever does not own the port.
  assign m0_gnt   = (st_busy | st_resp) && (owner_q == OWN_M0);
  assign m1_gnt   = (st_busy | st_resp) && (owner_q == OWN_M1);
  assign m0_done  = st_resp && (owner_q == OWN_M0);
  assign m1_done  = st_resp && (owner_q == OWN_M1);
  assign m0_rdata = m0_done ? rdata_q : '0;
  assign m1_rdata = m1_done ? rdata_q : '0;
  assign m0_err   = m0_done & err_q;
  assign m1_err   = m1_done & err_q;

  // CPU stays frozen until its own completion cycle.
  assign cpu_stall = m0_req & ~m0_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, read, arbitration, timeout, reset mid-transfer, early drop, back-to-back.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
// Summary line reports checks and errors.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ready;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic        cpu_stall;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .s_req     (s_req),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .cpu_stall (cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ready = 0; s_rdata = '0;
    tick(); tick();
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err} !== 6'b0) begin
      errors++; $display("FAIL reset_master_flags: got %b expected 000000",
                         {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err});
    end
    checks++;
    if ({s_req, s_we} !== 2'b00) begin
      errors++; $display("FAIL reset_slave_ctrl: got %b expected 00", {s_req, s_we});
    end
    checks++;
    if ((s_addr | s_wdata | m0_rdata | m1_rdata) !== 64'h0) begin
      errors++; $display("FAIL reset_data_regs: got addr=%0h wdata=%0h expected 0", s_addr, s_wdata);
    end
    tick();
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if ({s_req, cpu_stall} !== 2'b00) begin
      errors++; $display("FAIL reset_idle: got s_req,stall=%b expected 00", {s_req, cpu_stall});
    end
  endtask

  task automatic test_m0_read();
    int stall_cnt = 0;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 64'h40;
    #1; stall_cnt += int'(cpu_stall);
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL read_req_cycle_sreq: got %b expected 0", s_req);
    end
    tick(); #1; stall_cnt += int'(cpu_stall);
    checks++;
    if ({s_req, s_we, m0_gnt, m1_gnt} !== 4'b1010 || s_addr !== 64'h40) begin
      errors++; $display("FAIL read_busy: got req,we,g0,g1=%b addr=%0h expected 1010 addr=40",
                         {s_req, s_we, m0_gnt, m1_gnt}, s_addr);
    end
    tick();
    s_ready = 1; s_rdata = 64'hDEADBEEF;
    #1; stall_cnt += int'(cpu_stall);
    checks++;
    if (m0_done !== 1'b0) begin
      errors++; $display("FAIL read_early_done: got %b expected 0", m0_done);
    end
    tick();
    s_ready = 0; s_rdata = '0;
    #1; stall_cnt += int'(cpu_stall);
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== 64'hDEADBEEF || m0_err !== 1'b0 || m1_done !== 1'b0) begin
      errors++; $display("FAIL read_done: got done=%b rdata=%0h err=%b m1_done=%b expected 1 deadbeef 0 0",
                         m0_done, m0_rdata, m0_err, m1_done);
    end
    tick();
    m0_req = 0;
    #1;
    checks++;
    if ({s_req, m0_gnt, m0_done} !== 3'b000) begin
      errors++; $display("FAIL read_back_idle: got %b expected 000", {s_req, m0_gnt, m0_done});
    end
    checks++;
    if (stall_cnt !== 3) begin
      errors++; $display("FAIL read_stall_cycles: got %0d expected 3", stall_cnt);
    end
  endtask

  task automatic test_arbitration();
    logic own [4];
    int   ng = 0;
    logic exp_own;
    tick();
    rst = 1;
    tick();
    rst = 0;
    m0_req = 1; m0_we = 0; m0_addr = 64'h10;
    m1_req = 1; m1_we = 0; m1_addr = 64'h20;
    s_ready = 1; s_rdata = 64'h55;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      tick(); #1;
      if (s_req) begin
        own[ng] = m1_gnt;
        checks++;
        if ((m0_gnt ^ m1_gnt) !== 1'b1) begin
          errors++; $display("FAIL arb_single_owner: got g0=%b g1=%b expected exactly one", m0_gnt, m1_gnt);
        end
        ng++;
      end
    end
    checks++;
    if (ng !== 4) begin
      errors++; $display("FAIL arb_grant_count: got %0d expected 4", ng);
    end
    for (int i = 0; i < ng; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = (i % 2 == 1);
`else
      exp_own = 1'b0;
`endif
      checks++;
      if (own[i] !== exp_own) begin
        errors++; $display("FAIL arb_owner_%0d: got m%0d expected m%0d", i, own[i], exp_own);
      end
    end
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();
    s_ready = 0; s_rdata = '0;
    #1;
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL arb_drain: got s_req=%b expected 0", s_req);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    tick();
    m1_req = 1; m1_we = 1; m1_addr = 64'h80; m1_wdata = 64'h1234;
    s_ready = 0;
    for (int k = 1; k <= 17; k++) begin
      tick(); #1;
      if (k == 1) begin
        checks++;
        if ({s_req, s_we, m1_gnt, m0_gnt} !== 4'b1110 || s_addr !== 64'h80 || s_wdata !== 64'h1234) begin
          errors++; $display("FAIL timeout_issue: got ctrl=%b addr=%0h wdata=%0h expected 1110 80 1234",
                             {s_req, s_we, m1_gnt, m0_gnt}, s_addr, s_wdata);
        end
      end
      if (k < 17) early += int'(m1_done);
      if (k == 17) begin
        checks++;
        if (m1_done !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 64'h0 || cpu_stall !== 1'b0) begin
          errors++; $display("FAIL timeout_done: got done=%b err=%b rdata=%0h stall=%b expected 1 1 0 0",
                             m1_done, m1_err, m1_rdata, cpu_stall);
        end
      end
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL timeout_early_done: got %0d pulses expected 0", early);
    end
    tick();
    m1_req = 0; m1_we = 0;
    tick(); #1;
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got s_req=%b expected 0", s_req);
    end
  endtask

  task automatic test_ready_on_timeout();
    int early = 0;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 64'h200;
    s_ready = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) begin s_ready = 1; s_rdata = 64'hCAFEF00D; end
      if (k == 17) begin s_ready = 0; s_rdata = '0; end
      #1;
      if (k < 17) early += int'(m0_done);
      if (k == 17) begin
        checks++;
        if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 64'hCAFEF00D) begin
          errors++; $display("FAIL ready_at_timeout: got done=%b err=%b rdata=%0h expected 1 0 cafef00d",
                             m0_done, m0_err, m0_rdata);
        end
      end
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL ready_at_timeout_early: got %0d pulses expected 0", early);
    end
    tick();
    m0_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    int dones = 0;
    tick();
    m0_req = 1; m0_we = 1; m0_addr = 64'h100; m0_wdata = 64'hAB;
    s_ready = 0;
    tick(); #1;
    checks++;
    if (s_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got s_req=%b expected 1", s_req);
    end
    tick();
    rst = 1; m0_req = 0; m0_we = 0;
    tick();
    rst = 0;
    #1; dones += int'(m0_done | m1_done);
    checks++;
    if ({s_req, s_we, m0_gnt} !== 3'b000) begin
      errors++; $display("FAIL rstmid_abort: got req,we,gnt=%b expected 000", {s_req, s_we, m0_gnt});
    end
    tick(); #1; dones += int'(m0_done | m1_done);
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dones);
    end
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 64'h108;
    s_ready = 1; s_rdata = 64'h99;
    tick(); tick(); #1;
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== 64'h99 || m0_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_fresh: got done=%b rdata=%0h err=%b expected 1 99 0",
                         m0_done, m0_rdata, m0_err);
    end
    tick();
    m0_req = 0; s_ready = 0; s_rdata = '0;
    tick();
  endtask

  task automatic test_drop_req();
    int dones = 0;
    int sreqs = 0;
    logic [63:0] got_rdata = '0;
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 64'h300;
    s_ready = 0;
    tick(); #1; sreqs += int'(s_req);
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++; $display("FAIL drop_grant: got m1_gnt=%b expected 1", m1_gnt);
    end
    tick();
    m1_req = 0; s_ready = 1; s_rdata = 64'h77;
    #1; sreqs += int'(s_req);
    tick();
    s_ready = 0; s_rdata = '0;
    #1; sreqs += int'(s_req);
    if (m1_done) begin dones++; got_rdata = m1_rdata; end
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      sreqs += int'(s_req);
      dones += int'(m1_done);
    end
    checks++;
    if (dones !== 1 || got_rdata !== 64'h77) begin
      errors++; $display("FAIL drop_done: got %0d pulses rdata=%0h expected 1 pulse rdata=77", dones, got_rdata);
    end
    checks++;
    if (sreqs !== 2) begin
      errors++; $display("FAIL drop_single_xfer: got %0d s_req cycles expected 2", sreqs);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 64'h500;
    s_ready = 1; s_rdata = 64'h3C;
    for (int c = 1; c <= 9; c++) begin
      tick(); #1;
      if (m0_done) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    checks++;
    if (first !== 2 || second !== 5) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d,%0d expected 2,5", first, second);
    end
    m0_req = 0;
    tick(); tick(); tick();
    s_ready = 0; s_rdata = '0;
    #1;
    checks++;
    if ({s_req, cpu_stall} !== 2'b00) begin
      errors++; $display("FAIL b2b_drain: got %b expected 00", {s_req, cpu_stall});
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_arbitration();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid_transfer();
    test_drop_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
